// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALU_MODE_NONE  = 2'd0,
    ALU_MODE_ADD   = 2'd1,
    ALU_MODE_SUB   = 2'd2,
    ALU_MODE_FUNCT = 2'd3
  } alu_mode_e;

  // Per-state control word before reset/abort qualification.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       iord;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control: fixed ADD/SUB or funct-field decode, plus funct legality.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  alu_mode_e  mode,
  input  logic [5:0] funct,
  output logic [2:0] aluctl,
  output logic       valid
);

  logic [2:0] fn_ctl;

  // Unknown funct falls back to ADD and is flagged so writeback can be suppressed.
  always_comb begin
    fn_ctl = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  fn_ctl = ALU_ADD;
      FN_SUB:  fn_ctl = ALU_SUB;
      FN_AND:  fn_ctl = ALU_AND;
      FN_OR:   fn_ctl = ALU_OR;
      FN_SLT:  fn_ctl = ALU_SLT;
      default: valid  = 1'b0;
    endcase
  end

  always_comb begin
    aluctl = 3'b000;
    case (mode)
      ALU_MODE_ADD:   aluctl = ALU_ADD;
      ALU_MODE_SUB:   aluctl = ALU_SUB;
      ALU_MODE_FUNCT: aluctl = fn_ctl;
      default:        aluctl = 3'b000;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory-ready stalls and a stall watchdog.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT  = 15,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       pc_en,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluctl,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state_o
);

  localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;
  ctrl_t            ctl;
  alu_mode_e        alu_mode;
  logic             funct_valid;
  logic             ready, mem_state, stall, abort, run;

  assign ready     = mem_ready | ~MEM_WAIT_EN;
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign stall     = mem_state & ~ready;
  assign abort     = stall & (wait_cnt >= LIMIT_M1);
  assign run       = reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Counts consecutive stall cycles; any ready, state exit or abort clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              wait_cnt <= '0;
    else if (stall && !abort) wait_cnt <= wait_cnt + CNT_W'(1);
    else                     wait_cnt <= '0;
  end

  // ALU mode depends on state only, keeping the decoder out of the control loop.
  always_comb begin
    alu_mode = ALU_MODE_NONE;
    case (state_q)
      S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX: alu_mode = ALU_MODE_ADD;
      S_RTYPEEX:                             alu_mode = ALU_MODE_FUNCT;
      S_BEQEX:                               alu_mode = ALU_MODE_SUB;
      default:                               alu_mode = ALU_MODE_NONE;
    endcase
  end

  mips_alu_decoder u_alu_dec (
    .mode   (alu_mode),
    .funct  (funct),
    .aluctl (aluctl),
    .valid  (funct_valid)
  );

  always_comb begin
    state_d   = state_q;
    ctl       = '0;
    ctl.pcsrc = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        ctl.memread = 1'b1;
        ctl.alusrcb = SRCB_FOUR;
        ctl.irwrite = ready;
        ctl.pcwrite = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctl.alusrcb = SRCB_IMM_SH2;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d        = S_FETCH;
            ctl.illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        state_d     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctl.memread = 1'b1;
        ctl.iord    = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        ctl.memwrite = 1'b1;
        ctl.iord     = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_B;
        state_d     = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        ctl.regwrite = funct_valid;
        ctl.regdst   = 1'b1;
        state_d      = S_FETCH;
      end
      S_BEQEX: begin
        ctl.alusrca = 1'b1;
        ctl.pcsrc   = PCSRC_ALUOUT;
        ctl.branch  = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctl.regwrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_JEX: begin
        ctl.pcsrc   = PCSRC_JUMP;
        ctl.pcwrite = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Watchdog abort restarts fetch without committing any write.
    if (abort) begin
      state_d      = S_FETCH;
      ctl.memwrite = 1'b0;
      ctl.irwrite  = 1'b0;
      ctl.pcwrite  = 1'b0;
    end
  end

  // Strobes are held low while reset is asserted.
  assign memread    = run & ctl.memread;
  assign memwrite   = run & ctl.memwrite;
  assign irwrite    = run & ctl.irwrite;
  assign pc_en      = run & (ctl.pcwrite | (ctl.branch & zero));
  assign regwrite   = run & ctl.regwrite;
  assign illegal_op = run & ctl.illegal_op;
  assign mem_err    = run & abort;
  assign iord       = ctl.iord;
  assign pcsrc      = ctl.pcsrc;
  assign alusrca    = ctl.alusrca;
  assign alusrcb    = ctl.alusrcb;
  assign regdst     = ctl.regdst;
  assign memtoreg   = ctl.memtoreg;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for mips_multicycle_ctrl; expected control words are hand-derived.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       memread, memwrite, irwrite, iord, pc_en, alusrca;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] aluctl;
  logic       regwrite, regdst, memtoreg, illegal_op, mem_err;
  logic [3:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  // Layout: {memread,memwrite,irwrite,iord}_{pc_en,pcsrc}_{alusrca,alusrcb}_aluctl_{regwrite,regdst,memtoreg}_{illegal_op,mem_err}_state
  localparam logic [21:0] V_RESET       = 22'b0000_000_001_010_000_00_0000;
  localparam logic [21:0] V_FETCH_RDY   = 22'b1010_100_001_010_000_00_0000;
  localparam logic [21:0] V_FETCH_STALL = 22'b1000_000_001_010_000_00_0000;
  localparam logic [21:0] V_FETCH_ABORT = 22'b1000_000_001_010_000_01_0000;
  localparam logic [21:0] V_DECODE      = 22'b0000_000_011_010_000_00_0001;
  localparam logic [21:0] V_DECODE_ILL  = 22'b0000_000_011_010_000_10_0001;
  localparam logic [21:0] V_MEMADR      = 22'b0000_000_110_010_000_00_0010;
  localparam logic [21:0] V_MEMRD       = 22'b1001_000_000_000_000_00_0011;
  localparam logic [21:0] V_MEMWB       = 22'b0000_000_000_000_101_00_0100;
  localparam logic [21:0] V_MEMWR       = 22'b0101_000_000_000_000_00_0101;
  localparam logic [21:0] V_RTEX_SLT    = 22'b0000_000_100_111_000_00_0110;
  localparam logic [21:0] V_RTEX_BAD    = 22'b0000_000_100_010_000_00_0110;
  localparam logic [21:0] V_RTWB        = 22'b0000_000_000_000_110_00_0111;
  localparam logic [21:0] V_RTWB_BAD    = 22'b0000_000_000_000_010_00_0111;
  localparam logic [21:0] V_BEQ_T       = 22'b0000_101_100_110_000_00_1000;
  localparam logic [21:0] V_BEQ_N       = 22'b0000_001_100_110_000_00_1000;
  localparam logic [21:0] V_ADDIEX      = 22'b0000_000_110_010_000_00_1001;
  localparam logic [21:0] V_ADDIWB      = 22'b0000_000_000_000_100_00_1010;
  localparam logic [21:0] V_JEX         = 22'b0000_110_000_000_000_00_1011;

  mips_multicycle_ctrl #(.WAIT_LIMIT(15), .MEM_WAIT_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .iord       (iord),
    .pc_en      (pc_en),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluctl     (aluctl),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .illegal_op (illegal_op),
    .mem_err    (mem_err),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] obs();
    return {memread, memwrite, irwrite, iord, pc_en, pcsrc, alusrca, alusrcb, aluctl,
            regwrite, regdst, memtoreg, illegal_op, mem_err, state_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    tick(); tick();
    #1; vectors++; if (obs() !== V_RESET) begin miscompares++; $display("FAIL reset_idle: got %b want %b", obs(), V_RESET); end
    mem_ready = 1'b1;
    #1; vectors++; if (obs() !== V_RESET) begin miscompares++; $display("FAIL reset_ready_gated: got %b want %b", obs(), V_RESET); end
    mem_ready = 1'b0;
    reset = 1'b1;
    #1; vectors++; if (obs() !== V_FETCH_STALL) begin miscompares++; $display("FAIL reset_release_stall: got %b want %b", obs(), V_FETCH_STALL); end
  endtask

  task automatic test_lw();
    op = 6'b100011; funct = 6'd4; mem_ready = 1'b1;
    #1; vectors++; if (obs() !== V_FETCH_RDY) begin miscompares++; $display("FAIL lw_fetch: got %b want %b", obs(), V_FETCH_RDY); end
    tick(); vectors++; if (obs() !== V_DECODE) begin miscompares++; $display("FAIL lw_decode: got %b want %b", obs(), V_DECODE); end
    tick(); vectors++; if (obs() !== V_MEMADR) begin miscompares++; $display("FAIL lw_memadr: got %b want %b", obs(), V_MEMADR); end
    tick(); vectors++; if (obs() !== V_MEMRD) begin miscompares++; $display("FAIL lw_memrd: got %b want %b", obs(), V_MEMRD); end
    tick(); vectors++; if (obs() !== V_MEMWB) begin miscompares++; $display("FAIL lw_memwb: got %b want %b", obs(), V_MEMWB); end
    tick();
  endtask

  task automatic test_sw();
    op = 6'b101011; funct = 6'd8; mem_ready = 1'b1;
    #1; vectors++; if (obs() !== V_FETCH_RDY) begin miscompares++; $display("FAIL sw_fetch: got %b want %b", obs(), V_FETCH_RDY); end
    tick(); vectors++; if (obs() !== V_DECODE) begin miscompares++; $display("FAIL sw_decode: got %b want %b", obs(), V_DECODE); end
    tick(); vectors++; if (obs() !== V_MEMADR) begin miscompares++; $display("FAIL sw_memadr: got %b want %b", obs(), V_MEMADR); end
    for (int c = 0; c < 4; c++) begin
      tick();
      mem_ready = (c == 3);
      #1; vectors++; if (obs() !== V_MEMWR) begin miscompares++; $display("FAIL sw_memwr_cycle%0d: got %b want %b", c, obs(), V_MEMWR); end
    end
    tick();
  endtask

  task automatic test_rtype();
    op = 6'b000000; funct = 6'b101010; mem_ready = 1'b1;
    #1; vectors++; if (obs() !== V_FETCH_RDY) begin miscompares++; $display("FAIL slt_fetch: got %b want %b", obs(), V_FETCH_RDY); end
    tick(); tick(); vectors++; if (obs() !== V_RTEX_SLT) begin miscompares++; $display("FAIL slt_rtypeex: got %b want %b", obs(), V_RTEX_SLT); end
    tick(); vectors++; if (obs() !== V_RTWB) begin miscompares++; $display("FAIL slt_rtypewb: got %b want %b", obs(), V_RTWB); end
    tick(); funct = 6'b111111;
    #1; vectors++; if (obs() !== V_FETCH_RDY) begin miscompares++; $display("FAIL badfn_fetch: got %b want %b", obs(), V_FETCH_RDY); end
    tick(); tick(); vectors++; if (obs() !== V_RTEX_BAD) begin miscompares++; $display("FAIL badfn_rtypeex: got %b want %b", obs(), V_RTEX_BAD); end
    tick(); vectors++; if (obs() !== V_RTWB_BAD) begin miscompares++; $display("FAIL badfn_rtypewb: got %b want %b", obs(), V_RTWB_BAD); end
    tick();
  endtask

  task automatic test_beq();
    op = 6'b000100; funct = 6'd0; zero = 1'b1;
    tick(); tick(); vectors++; if (obs() !== V_BEQ_T) begin miscompares++; $display("FAIL beq_taken: got %b want %b", obs(), V_BEQ_T); end
    tick(); zero = 1'b0;
    #1; vectors++; if (obs() !== V_FETCH_RDY) begin miscompares++; $display("FAIL beq_refetch: got %b want %b", obs(), V_FETCH_RDY); end
    tick(); tick(); vectors++; if (obs() !== V_BEQ_N) begin miscompares++; $display("FAIL beq_not_taken: got %b want %b", obs(), V_BEQ_N); end
    tick();
  endtask

  task automatic test_jump();
    op = 6'b000010; funct = 6'b010000;
    tick(); tick(); vectors++; if (obs() !== V_JEX) begin miscompares++; $display("FAIL j_jex: got %b want %b", obs(), V_JEX); end
    tick();
  endtask

  task automatic test_addi();
    op = 6'b001000;
    tick(); tick(); vectors++; if (obs() !== V_ADDIEX) begin miscompares++; $display("FAIL addi_ex: got %b want %b", obs(), V_ADDIEX); end
    tick(); vectors++; if (obs() !== V_ADDIWB) begin miscompares++; $display("FAIL addi_wb: got %b want %b", obs(), V_ADDIWB); end
    tick();
  endtask

  task automatic test_illegal();
    op = 6'b111111;
    tick(); vectors++; if (obs() !== V_DECODE_ILL) begin miscompares++; $display("FAIL illegal_decode: got %b want %b", obs(), V_DECODE_ILL); end
    tick(); vectors++; if (obs() !== V_FETCH_RDY) begin miscompares++; $display("FAIL illegal_refetch: got %b want %b", obs(), V_FETCH_RDY); end
  endtask

  task automatic test_ready_wins();
    op = 6'b100011; funct = 6'd0;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c != 0) tick();
      #1; vectors++; if (obs() !== V_MEMRD) begin miscompares++; $display("FAIL rdwin_stall%0d: got %b want %b", c, obs(), V_MEMRD); end
    end
    tick(); mem_ready = 1'b1;
    #1; vectors++; if (obs() !== V_MEMRD) begin miscompares++; $display("FAIL rdwin_limit_ready: got %b want %b", obs(), V_MEMRD); end
    tick(); vectors++; if (obs() !== V_MEMWB) begin miscompares++; $display("FAIL rdwin_memwb: got %b want %b", obs(), V_MEMWB); end
    tick();
  endtask

  task automatic test_watchdog();
    mem_ready = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c != 1) tick();
      #1;
      vectors++;
      if (c < 15) begin
        if (obs() !== V_FETCH_STALL) begin miscompares++; $display("FAIL wdog_stall%0d: got %b want %b", c, obs(), V_FETCH_STALL); end
      end else begin
        if (obs() !== V_FETCH_ABORT) begin miscompares++; $display("FAIL wdog_abort: got %b want %b", obs(), V_FETCH_ABORT); end
      end
    end
    tick(); vectors++; if (obs() !== V_FETCH_STALL) begin miscompares++; $display("FAIL wdog_restart: got %b want %b", obs(), V_FETCH_STALL); end
  endtask

  task automatic test_reset_mid();
    op = 6'b100011; mem_ready = 1'b1;
    #1; vectors++; if (obs() !== V_FETCH_RDY) begin miscompares++; $display("FAIL rstmid_fetch: got %b want %b", obs(), V_FETCH_RDY); end
    tick(); tick(); tick(); mem_ready = 1'b0;
    #1; vectors++; if (obs() !== V_MEMRD) begin miscompares++; $display("FAIL rstmid_memrd: got %b want %b", obs(), V_MEMRD); end
    reset = 1'b0;
    #1; vectors++; if (obs() !== V_RESET) begin miscompares++; $display("FAIL rstmid_async: got %b want %b", obs(), V_RESET); end
    tick(); vectors++; if (obs() !== V_RESET) begin miscompares++; $display("FAIL rstmid_held: got %b want %b", obs(), V_RESET); end
    reset = 1'b1; mem_ready = 1'b1;
    #1; vectors++; if (obs() !== V_FETCH_RDY) begin miscompares++; $display("FAIL rstmid_release: got %b want %b", obs(), V_FETCH_RDY); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_jump();
    test_addi();
    test_illegal();
    test_ready_wins();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
